// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the multicycle fetch sequencer.
//   - state_t     : fetch controller states (IDLE, REQ, HOLD, ERR)
//   - RESET_INSTR : value the held instruction register takes on reset
//   - WAIT_W      : width of the fetch wait counter
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam int RESET_INSTR = 0;
   localparam int WAIT_W      = 8;

endpackage

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
//   Bundles the instruction-memory request/ack port and the instruction
//   hand-off to decode/execute.
//   Ports (as seen from the master, i.e. the fetch sequencer):
//     imem_req    out  fetch request to instruction memory
//     imem_addr   out  fetch address
//     imem_ack    in   imem_rdata is valid this cycle
//     imem_rdata  in   fetched instruction word
//     instr       out  registered instruction for decode/execute
//     instr_valid out  instr is valid and offered
//     instr_ready in   decode/execute consumes instr this cycle (low = stall)
//
//   Handshake rules: memory side -- imem_ack is only meaningful while
//   imem_req is high; the word is taken on the first cycle with both high.
//   Decode side -- instr is transferred on a cycle where instr_valid and
//   instr_ready are both high; while instr_valid is high and instr_ready is
//   low, instr is held stable.
// -----------------------------------------------------------------------------
interface fetch_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;
   logic [DATA_W-1:0] instr;
   logic              instr_valid;
   logic              instr_ready;

   modport master (
      output imem_req, imem_addr, instr, instr_valid,
      input  imem_ack, imem_rdata, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_valid,
      output imem_ack, imem_rdata, instr_ready
   );
endinterface

// File: rtl/fetch_sequencer_wait_counter.sv
// -----------------------------------------------------------------------------
// wait_counter
//   Counts REQ cycles that went by without an ack and flags when the count
//   reaches MAX_WAIT-1 (the last cycle before a fetch timeout).
//   Ports:
//     clk, reset  clock and synchronous active-high reset
//     clear       return count to zero (takes priority over inc)
//     inc         increment count
//     count       current wait count
//     at_limit    count == MAX_WAIT-1
// -----------------------------------------------------------------------------
module wait_counter
   import fetch_pkg::*;
#(
   parameter int MAX_WAIT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              inc,
   output logic [WAIT_W-1:0] count,
   output logic              at_limit
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + WAIT_W'(1);
      end
   end

   assign at_limit = (count == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Multicycle fetch controller. Requests the instruction at pc, waits a
//   variable number of cycles for imem_ack, holds the fetched word for
//   decode/execute, and pulses pc_en for one cycle when that word is consumed.
//   A watchdog moves to a sticky error state if no ack arrives within
//   MAX_WAIT request cycles; only reset leaves that state.
//   Ports:
//     clk          system clock (rising edge)
//     reset        synchronous active-high reset
//     pc           current PC from the PC register
//     pc_en        one-cycle PC register write enable
//     bus          fetch_if.master: memory req/ack port + instr hand-off
//     timeout_err  sticky fetch-timeout flag
//     fsm_state    current controller state (observability)
//     wait_count   current wait counter value (observability)
// -----------------------------------------------------------------------------
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   output logic              pc_en,
   fetch_if.master           bus,
   output logic              timeout_err,
   output state_t            fsm_state,
   output logic [WAIT_W-1:0] wait_count
);

   state_t            state;
   logic [DATA_W-1:0] instr_q;
   logic              err_q;
   logic              cnt_clear;
   logic              cnt_inc;
   logic              at_limit;

   // The counter only runs in REQ. It is cleared when the fetch ends either
   // way (ack or timeout) so every new REQ phase starts from zero.
   always_comb begin
      cnt_clear = 1'b0;
      cnt_inc   = 1'b0;
      if (state == REQ) begin
         cnt_clear = bus.imem_ack || at_limit;
         cnt_inc   = !bus.imem_ack && !at_limit;
      end
   end

   wait_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (cnt_clear),
      .inc      (cnt_inc),
      .count    (wait_count),
      .at_limit (at_limit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         instr_q <= DATA_W'(RESET_INSTR);
         err_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: state <= REQ;
            REQ: begin
               // An ack on the threshold cycle still completes the fetch.
               if (bus.imem_ack) begin
                  instr_q <= bus.imem_rdata;
                  state   <= HOLD;
               end else if (at_limit) begin
                  err_q <= 1'b1;
                  state <= ERR;
               end
            end
            HOLD: begin
               if (bus.instr_ready) begin
                  state <= REQ;
               end
            end
            ERR: state <= ERR;
            default: state <= IDLE;
         endcase
      end
   end

   // pc only changes on a pc_en edge, which can only occur leaving HOLD, so
   // pc is stable for the whole REQ phase and can be passed straight through.
   assign bus.imem_addr   = pc;
   assign bus.imem_req    = (state == REQ);
   assign bus.instr       = instr_q;
   assign bus.instr_valid = (state == HOLD);
   // The PC register advances in the same cycle decode consumes instr.
   assign pc_en           = (state == HOLD) && bus.instr_ready;
   assign timeout_err     = err_q;
   assign fsm_state       = state;

endmodule
